// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: autonomous exhaustive scan-test sequencer.
// Loads all 2^CHAIN_LEN patterns serially (LSB first), inserts one capture
// cycle per pattern, and unloads each response while the next pattern loads.
// Optional feature macro: SCAN_SIG_EN (16-bit serial signature, x^16+x^15+x^2+1).
module scan_test_ctrl #(
  parameter int unsigned CHAIN_LEN = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 START,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 RESP_VALID,
  output logic [15:0]          SIGNATURE
);

  localparam int unsigned BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned PAT_W = CHAIN_LEN + 1;
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'((1 << CHAIN_LEN) - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [PAT_W-1:0]     pat_q, pat_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [CHAIN_LEN-1:0] buf_q, buf_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sample_c;
  logic                 start_c;

  // Next-state, counters, response capture and registered CUT-side outputs
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    bit_d        = bit_q;
    buf_d        = buf_q;
    resp_d       = resp_q;
    resp_valid_d = 1'b0;
    sample_c     = 1'b0;
    start_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          start_c = 1'b1;
          state_d = SHIFT;
          pat_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        // The pattern-0 load has no prior capture to unload, so its samples are dropped
        sample_c = (pat_q != '0);
        if (bit_q == BIT_LAST) begin
          state_d = CAPTURE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      CAPTURE: begin
        if (pat_q == PAT_LAST) begin
          state_d = UNLOAD;
        end else begin
          state_d = SHIFT;
          pat_d   = pat_q + PAT_W'(1);
        end
      end
      UNLOAD: begin
        sample_c = 1'b1;
        if (bit_q == BIT_LAST) begin
          state_d = FINISH;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sample_c) begin
      buf_d[bit_q] = SO;
      if (bit_q == BIT_LAST) begin
        resp_d       = buf_d;
        resp_valid_d = 1'b1;
      end
    end

    se_d   = (state_d == SHIFT) || (state_d == UNLOAD);
    si_d   = (state_d == SHIFT) ? pat_d[bit_d] : 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      pat_q        <= '0;
      bit_q        <= '0;
      buf_q        <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      se_q         <= 1'b0;
      si_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      bit_q        <= bit_d;
      buf_q        <= buf_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      se_q         <= se_d;
      si_q         <= si_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign SE         = se_q;
  assign SI         = si_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign RESP       = resp_q;
  assign RESP_VALID = resp_valid_q;

`ifdef SCAN_SIG_EN
  logic [15:0] sig_q, sig_d;
  logic        fb_c;

  // Serial signature over every delivered SO sample; cleared when a run starts
  always_comb begin
    sig_d = sig_q;
    fb_c  = sig_q[15] ^ SO;
    if (start_c) begin
      sig_d = '0;
    end else if (sample_c) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (fb_c ? 16'h8005 : 16'h0000);
    end
  end

  // Signature register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign SIGNATURE = sig_q;
`else
  assign SIGNATURE = 16'h0000;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: behavioural scan chain as CUT, scoreboard of
// expected responses popped by an independent monitor on RESP_VALID.
module tb_scan_test_ctrl;

  localparam int unsigned CL = 4;

  logic          CLK;
  logic          RSTn;
  logic          START;
  logic          SO;
  logic          SE;
  logic          SI;
  logic          BUSY;
  logic          DONE;
  logic [CL-1:0] RESP;
  logic          RESP_VALID;
  logic [15:0]   SIGNATURE;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int mode = 0;           // 0 loopback chain, 1 SO tied 0, 2 SO tied 1
  logic [CL-1:0] exp_q[$];
  logic [CL-1:0] chain = '0;

  scan_test_ctrl #(.CHAIN_LEN(CL)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .START      (START),
    .SO         (SO),
    .SE         (SE),
    .SI         (SI),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .RESP       (RESP),
    .RESP_VALID (RESP_VALID),
    .SIGNATURE  (SIGNATURE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // CUT: chain shifts toward SO when SE=1, holds contents on capture
  always @(posedge CLK) if (SE) chain <= {SI, chain[CL-1:1]};
  assign SO = (mode == 0) ? chain[0] : ((mode == 2) ? 1'b1 : 1'b0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sig_model(input int m);
    logic [15:0]   s;
    logic [CL-1:0] pv;
    logic          sb;
    logic          fb;
    s = 16'h0000;
    for (int p = 0; p < (1 << CL); p++) begin
      pv = CL'(p);
      for (int i = 0; i < CL; i++) begin
        sb = (m == 0) ? pv[i] : ((m == 2) ? 1'b1 : 1'b0);
        fb = s[15] ^ sb;
        s  = {s[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    return s;
  endfunction

  // Monitor: pops the scoreboard whenever a response is presented
  always @(negedge CLK) begin
    if (RSTn && RESP_VALID) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL resp_unexpected: got %h expected none", RESP);
      end else begin
        check("resp", 32'(RESP), 32'(exp_q.pop_front()));
      end
    end
    if (RSTn && DONE) begin
      done_cnt++;
      check("done_with_last_resp", 32'(RESP_VALID), 32'd1);
    end
  end

  // One run from IDLE; optional stray STARTs and optional mid-run reset abort
  task automatic run(input int m, input bit extra_start, input int abort_at);
    int n;
    bit got;
    int done0;
    logic [15:0] exp_sig;
    mode  = m;
    done0 = done_cnt;
    for (int p = 0; p < (1 << CL); p++)
      exp_q.push_back((m == 0) ? CL'(p) : ((m == 2) ? {CL{1'b1}} : {CL{1'b0}}));
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    got = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        check("busy_first", 32'(BUSY), 32'd1);
        check("se_first", 32'(SE), 32'd1);
        check("si_first", 32'(SI), 32'd0);
      end
      if (n >= 6 && n <= 10) begin
        check("pat1_se", 32'(SE), (n != 10) ? 32'd1 : 32'd0);
        check("pat1_si", 32'(SI), (n == 6) ? 32'd1 : 32'd0);
      end
      START = (extra_start && (n == 10 || n == 40)) ? 1'b1 : 1'b0;
      if (abort_at == n) begin
        #2 RSTn = 1'b0;
        #1;
        check("abort_se", 32'(SE), 32'd0);
        check("abort_si", 32'(SI), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_sig", 32'(SIGNATURE), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (20) @(negedge CLK);
        check("abort_no_done", 32'(done_cnt), 32'(done0));
        check("abort_idle", 32'(BUSY), 32'd0);
        return;
      end
      if (DONE) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no DONE expected DONE at cycle 85");
    end else begin
      check("done_cycle", 32'(n), 32'd85);
      check("busy_finish", 32'(BUSY), 32'd1);
`ifdef SCAN_SIG_EN
      exp_sig = sig_model(m);
`else
      exp_sig = 16'h0000;
`endif
      check("signature", 32'(SIGNATURE), 32'(exp_sig));
    end
    @(negedge CLK);
    check("done_pulse_end", 32'(DONE), 32'd0);
    check("busy_end", 32'(BUSY), 32'd0);
    check("resp_all_seen", 32'(exp_q.size()), 32'd0);
    check("single_done", 32'(done_cnt), 32'(done0 + 1));
    check("sig_hold", 32'(SIGNATURE), 32'(exp_sig));
  endtask

  initial begin
    RSTn  = 1'b0;
    START = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_se", 32'(SE), 32'd0);
    check("rst_si", 32'(SI), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_resp", 32'(RESP), 32'd0);
    check("rst_resp_valid", 32'(RESP_VALID), 32'd0);
    check("rst_sig", 32'(SIGNATURE), 32'd0);
    RSTn = 1'b1;
    @(negedge CLK);

    run(0, 1'b0, 0);   // loopback: RESP 0..15
    run(1, 1'b0, 0);   // SO tied 0
    run(2, 1'b0, 0);   // SO tied 1
    run(0, 1'b1, 0);   // stray STARTs during the run
    run(0, 1'b0, 30);  // reset abort at cycle 30
    run(0, 1'b0, 0);   // clean run after abort

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_test_ctrl.md
# scan_test_ctrl

Autonomous scan-test controller sitting directly upstream of the scan-chain circuit under test (TRCUT). It applies an exhaustive set of patterns serially through SI/SE, inserts one capture cycle per pattern, and collects the SO stream. Chain unload overlaps with the next pattern's load. Responses are presented per pattern and, optionally, compacted into a serial signature, replacing hand-written stimulus sequences.

## Interface
- CHAIN_LEN, 4: scan-chain length in cells; patterns applied = 2^CHAIN_LEN.
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- START  in  1  begin a run; sampled only in IDLE.
- SO  in  1  scan-out from CUT.
- SE  out  1  scan enable to CUT (1 = shift, 0 = capture); registered.
- SI  out  1  scan-in to CUT; registered.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle pulse at end of run.
- RESP  out  CHAIN_LEN  last unloaded response; RESP[i] = SO sampled in shift cycle i.
- RESP_VALID  out  1  one-cycle pulse when RESP updates.
- SIGNATURE  out  16  serial signature (see Configuration).

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD, FINISH.
- IDLE: SE=0, SI=0. START=1 -> SHIFT with pattern counter = 0, bit counter = 0, signature cleared.
- SHIFT: CHAIN_LEN cycles, SE=1, SI = pattern[bit], LSB first (pattern 1 -> SI sequence 1,0,0,0). Bit counter wraps at CHAIN_LEN-1 -> CAPTURE.
- CAPTURE: one cycle, SE=0, SI=0. If pattern counter = 2^CHAIN_LEN-1 -> UNLOAD; else pattern counter +1 -> SHIFT.
- UNLOAD: CHAIN_LEN cycles, SE=1, SI=0, unloading final response -> FINISH.
- FINISH: one cycle, DONE=1 -> IDLE.
- SO sampling: at the rising edge ending each shift cycle of SHIFT/UNLOAD (CUT shifts on the same edge, so the pre-shift value is sampled). Samples taken during the very first SHIFT (pattern 0 load) are discarded; every later SHIFT and the UNLOAD deliver one response.
- RESP loaded with the CHAIN_LEN samples and RESP_VALID pulsed the cycle after the last sample of each delivering phase; exactly 2^CHAIN_LEN pulses per run.
- Pattern counter width CHAIN_LEN+1 bits internally; terminal compare on 2^CHAIN_LEN-1, no wrap.
- START while BUSY ignored. START held high in FINISH/IDLE restarts on the IDLE cycle.

## Timing
- Reset values: SE=0, SI=0, BUSY=0, DONE=0, RESP=0, RESP_VALID=0, SIGNATURE=0; state IDLE.
- RSTn low mid-run: immediate abort to reset values; no DONE; next run needs new START.
- SE/SI change one clock after the transition decision (registered); first SI bit valid the cycle after START sampled.
- BUSY high from cycle after START through FINISH inclusive.
- Run length from START edge to DONE: 2^CHAIN_LEN*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles (CHAIN_LEN=4: 85).
- RESP_VALID and DONE never coincide except: final RESP_VALID lands in FINISH cycle together with DONE.

## Configuration
- SCAN_SIG_EN defined: 16-bit serial signature register, polynomial x^16+x^15+x^2+1. Every non-discarded SO sample: fb = SIG[15]^SO; SIG = {SIG[14:0],0} ^ (fb ? 16'h8005 : 0). Cleared on START; final value stable from DONE until next START.
- SCAN_SIG_EN undefined: no signature logic; SIGNATURE tied to 16'h0000.

## Test plan
- Reset then START with CUT whose capture holds chain contents (loopback) -> RESP_VALID 16 times, RESP = 0,1,...,15 in order; DONE 85 cycles after START.
- Pattern 1 load -> SI = 1,0,0,0 on four consecutive SE=1 cycles, followed by exactly one SE=0 cycle.
- SO tied 0 -> all RESP = 0; with SCAN_SIG_EN, SIGNATURE = 16'h0000 at DONE.
- SO tied 1, SCAN_SIG_EN -> SIGNATURE equals 64-step reference model of the polynomial from 0 seed; bench compares at DONE.
- START pulsed at cycle 10 and 40 of a run -> ignored; single DONE at cycle 85.
- RSTn low at cycle 30 -> SE=0, SI=0, BUSY=0 asynchronously, no DONE; subsequent START gives full clean run.
